// File: rtl/converter_pkg.sv
// Shared constants and types for the fixed-point to IEEE-754 single converter.
// Holds field widths, the exponent bias and the converter FSM state encoding.
package converter_pkg;

    localparam int FLOAT_BIAS = 127;
    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int FIX_W      = 32;

    // A magnitude normalized so that bit FIX_W-1 is set has weight
    // 2^(FIX_W-1), so the biased exponent starts from this offset.
    localparam int E_OFFS = FLOAT_BIAS + FIX_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK
    } state_e;

endpackage

// File: rtl/float_pack.sv
// Combinational packer: builds the IEEE-754 single word from sign, zero flag,
// biased exponent and normalized fraction, with overflow and underflow handling.
//   sign_i  : result sign
//   zero_i  : operand magnitude was zero (forces +0.0)
//   e_i     : 10-bit signed biased exponent
//   mag_i   : normalized magnitude below the leading one, truncated to 23 bits
//   float_o : packed {sign, exp, frac}
module float_pack
    import converter_pkg::*;
(
    input  logic                    sign_i,
    input  logic                    zero_i,
    input  logic signed [9:0]       e_i,
    input  logic [FRAC_W-1:0]       mag_i,
    output logic [FIX_W-1:0]        float_o
);

    always_comb begin
        float_o = '0;
        if (zero_i) begin
            float_o = '0;
        end else if (e_i >= 10'sd255) begin
            float_o = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (e_i <= 10'sd0) begin
            // No denormals: anything below the normal range becomes signed zero.
            float_o = {sign_i, {(FIX_W-1){1'b0}}};
        end else begin
            float_o = {sign_i, e_i[EXP_W-1:0], mag_i};
        end
    end

endmodule

// File: rtl/converter.sv
// Multi-cycle converter from scaled two's-complement fixed point to IEEE-754
// single: value = fixed * 2^exp_in, normalized one bit per cycle.
//   clk, reset : clock, synchronous active-high reset
//   fixed      : two's-complement mantissa
//   exp_in     : signed power-of-two scale
//   load_new   : start pulse, restarts any conversion in progress
//   float      : registered result, held between conversions
//   done       : one-cycle pulse with each float update
module converter
    import converter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [FIX_W-1:0]    fixed,
    input  logic [EXP_W-1:0]    exp_in,
    input  logic                load_new,
    output logic [FIX_W-1:0]    float,
    output logic                done
);

    state_e             state_q, state_d;
    logic [FIX_W-1:0]   mag_q, mag_d;
    logic [5:0]         n_q, n_d;
    logic signed [9:0]  scale_q, scale_d;
    logic               sign_q, sign_d;
    logic               zero_q, zero_d;
    logic [FIX_W-1:0]   float_q, float_d;
    logic               done_q, done_d;

    logic [FIX_W-1:0]   abs_w;
    logic signed [9:0]  e_w;
    logic [FIX_W-1:0]   pack_w;

    // Negating 0x80000000 wraps back to 0x80000000, which read as unsigned
    // is exactly 2^31, so no special case is needed.
    assign abs_w = fixed[FIX_W-1] ? (~fixed + 32'd1) : fixed;

    assign e_w = 10'(E_OFFS) - $signed({4'd0, n_q}) + scale_q;

    float_pack u_pack (
        .sign_i  (sign_q),
        .zero_i  (zero_q),
        .e_i     (e_w),
        .mag_i   (mag_q[FIX_W-2:FIX_W-1-FRAC_W]),
        .float_o (pack_w)
    );

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        n_d     = n_q;
        scale_d = scale_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        float_d = float_q;
        done_d  = 1'b0;

        if (load_new) begin
            sign_d  = fixed[FIX_W-1];
            mag_d   = abs_w;
            scale_d = {{2{exp_in[EXP_W-1]}}, exp_in};
            n_d     = '0;
            zero_d  = 1'b0;
            state_d = NORM;
        end else begin
            case (state_q)
                NORM: begin
                    if (mag_q == '0) begin
                        zero_d  = 1'b1;
                        state_d = PACK;
                    end else if (mag_q[FIX_W-1]) begin
                        state_d = PACK;
                    end else begin
                        mag_d = mag_q << 1;
                        n_d   = n_q + 6'd1;
                    end
                end
                PACK: begin
                    float_d = pack_w;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            n_q     <= '0;
            scale_q <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            float_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            n_q     <= n_d;
            scale_q <= scale_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            float_q <= float_d;
            done_q  <= done_d;
        end
    end

    assign float = float_q;
    assign done  = done_q;

endmodule

// File: tb/tb_converter.sv
// Directed bench for converter: hand-computed float results, latencies,
// reset-mid-conversion and restart behaviour.
module tb_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fixed;
    logic [7:0]  exp_in;
    logic        load_new;
    logic [31:0] float;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    converter dut (
        .clk      (clk),
        .reset    (reset),
        .fixed    (fixed),
        .exp_in   (exp_in),
        .load_new (load_new),
        .float    (float),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load on one edge, wait for done (bounded), check latency, result,
    // that done is a single pulse and that float holds afterwards.
    task automatic convert(input string tag, input logic [31:0] f,
                           input logic [7:0] e, input logic [31:0] expv,
                           input int lat);
        int cyc;
        @(negedge clk);
        fixed    = f;
        exp_in   = e;
        load_new = 1'b1;
        @(posedge clk);
        #1 load_new = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_val"}, float, expv);
        @(posedge clk);
        #1;
        check({tag, "_done1"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, float, expv);
    endtask

    initial begin
        int dn;
        reset    = 1'b1;
        fixed    = '0;
        exp_in   = '0;
        load_new = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_float", float, 32'h0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert("one",     32'h0000_0001, 8'h00, 32'h3F80_0000, 33);
        convert("two",     32'h0000_0001, 8'h01, 32'h4000_0000, 33);
        convert("6p5",     32'h0000_000D, 8'hFF, 32'h40D0_0000, 30);
        convert("neg1",    32'hFFFF_FFFF, 8'h00, 32'hBF80_0000, 33);
        convert("minint",  32'h8000_0000, 8'h00, 32'hCF00_0000, 2);
        convert("zero",    32'h0000_0000, 8'h00, 32'h0000_0000, 2);
        convert("inf",     32'h7FFF_FFFF, 8'h7F, 32'h7F80_0000, 3);
        convert("flush",   32'h0000_0001, 8'h80, 32'h0000_0000, 33);
        convert("trunc9",  32'h0000_01FF, 8'h00, 32'h43FF_8000, 25);
        convert("trunc31", 32'h7FFF_FFFF, 8'h00, 32'h4EFF_FFFF, 3);
        convert("nflush",  32'hFFFF_FFFF, 8'h80, 32'h8000_0000, 33);
        convert("e255",    32'h8000_0000, 8'h61, 32'hFF80_0000, 2);
        convert("e254",    32'h4000_0000, 8'h61, 32'h7F00_0000, 3);
        convert("e1",      32'h0000_0001, 8'h82, 32'h0080_0000, 33);
        convert("e0",      32'h0000_0001, 8'h81, 32'h0000_0000, 33);
        convert("posmax",  32'h0000_0003, 8'h00, 32'h4040_0000, 32);

        // Reset in the middle of normalization.
        convert("pre_rst", 32'h0000_0005, 8'h00, 32'h40A0_0000, 31);
        @(negedge clk);
        fixed    = 32'h0000_0001;
        exp_in   = 8'h00;
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_float", float, 32'h0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done === 1'b1) dn++;
        end
        check("midrst_nodone", dn, 0);
        check("midrst_hold", float, 32'h0);

        // Restart mid-conversion: only the second result, one done.
        @(negedge clk);
        fixed    = 32'h0000_0001;
        exp_in   = 8'h00;
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        repeat (10) @(negedge clk);
        fixed    = 32'h0000_000D;
        exp_in   = 8'hFF;
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        dn = 0;
        repeat (45) begin
            @(posedge clk);
            #1 if (done === 1'b1) dn++;
        end
        check("restart_dones", dn, 1);
        check("restart_val", float, 32'h40D0_0000);

        // load_new held in IDLE: the last capture wins.
        @(negedge clk);
        fixed    = 32'h0000_0002;
        exp_in   = 8'h00;
        load_new = 1'b1;
        @(negedge clk);
        fixed    = 32'hFFFF_FFFD;
        @(negedge clk);
        load_new = 1'b0;
        dn = 0;
        repeat (45) begin
            @(posedge clk);
            #1 if (done === 1'b1) dn++;
        end
        check("held_dones", dn, 1);
        check("held_val", float, 32'hC040_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/converter.md
Name: converter

Overview:
- Multi-cycle converter from a scaled two's-complement fixed-point value to an IEEE-754 single-precision float.
- Represented value = fixed × 2^exp_in; exp_in is a signed 8-bit power-of-two scale.
- Sits between fixed-point datapath blocks and float consumers. Operands load on a pulse; the result register updates when normalization completes.

Parameters:
- None. Widths are fixed: 32-bit input, 8-bit scale, 32-bit float.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- fixed  input  32  two's-complement integer mantissa
- exp_in  input  8  two's-complement scale exponent (-128..127)
- load_new  input  1  start pulse; operands sampled on the rising edge where high
- float  output  32  IEEE-754 single result {sign, exp[7:0], frac[22:0]}; registered
- done  output  1  one-cycle pulse, coincident with float update

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, float=32'h0000_0000, done=0.
  - Reset has priority over load_new on the same edge.
- States: IDLE, NORM, PACK.
- IDLE:
  - On load_new=1, capture the operands:
    - sign=fixed[31]
    - mag=|fixed| as 32-bit unsigned; 0x80000000 yields mag=2^31
    - scale=sext(exp_in)
    - n=0
  - Go to NORM.
- NORM, one step per cycle:
  - If mag==0: go to PACK with the zero flag set.
  - Else if mag[31]==1: go to PACK.
  - Else: mag<<=1, n+=1.
- PACK, computed in 10-bit signed arithmetic:
  - e = 158 - n + scale (158 = 127 bias + 31).
  - Zero flag set: float={sign=0, 31'b0}, i.e. +0.0.
  - e >= 255: float={sign, 8'hFF, 23'b0} (infinity).
  - e <= 0: float={sign, 31'b0} (flush to signed zero; no denormals).
  - Otherwise: float={sign, e[7:0], mag[30:8]}. mag[7:0] is truncated (round toward zero).
  - Assert done for this cycle, then return to IDLE.
- Latency:
  - From the loading edge, float and done update after n+2 cycles.
  - Maximum is 33 cycles (fixed=±1), and float must be valid no later than 34 cycles after load.
- float holds its last value between conversions. It changes only in PACK or on reset.
- load_new while in NORM or PACK aborts the conversion in progress and restarts with the new operands; no done pulse is issued for the aborted one.
- load_new held high in IDLE for multiple cycles: each edge re-captures. Only the last capture completes.
- Sign is taken from fixed only; exp_in never affects sign.

Decomposition:
- Shared package converter_pkg:
  - FLOAT_BIAS=127, EXP_W=8, FRAC_W=23, FIX_W=32
  - state enum {IDLE, NORM, PACK}
- One natural sub-module: float_pack. Combinational; takes sign, zero flag, 10-bit signed e, and normalized mag; produces the 32-bit float with inf/flush handling.
- Top level holds the FSM, abs, and shift/count registers.

Test Plan:
- fixed=1, exp_in=0, pulse load_new one cycle, wait 40 cycles -> float=32'h3F80_0000 (1.0), done pulsed once.
- fixed=1, exp_in=1 -> float=32'h4000_0000 (2.0).
- fixed=13, exp_in=8'hFF (-1) -> float=32'h40D0_0000 (6.5).
- fixed=32'hFFFF_FFFF, exp_in=0 -> float=32'hBF80_0000 (-1.0). Also fixed=32'h8000_0000, exp_in=0 -> 32'hCF00_0000.
- Boundaries:
  - fixed=0 -> 32'h0000_0000.
  - fixed=32'h7FFF_FFFF, exp_in=127 -> 32'h7F80_0000 (inf).
  - fixed=1, exp_in=-128 -> 32'h0000_0000 (flush).
  - fixed=32'h0000_01FF, exp_in=0 -> 32'h43FF_8000 (truncation check).
- Control:
  - Assert reset mid-NORM -> next edge float=0, no done.
  - Re-pulse load_new mid-conversion -> only the second result appears, with a single done.
